// File: rtl/izh_update_scheduler.sv
// Sequences one forward-Euler timestep over NUM_NEURONS Izhikevich neurons,
// sharing a single external calc_dv/calc_dw datapath in neuron index order.
module izh_update_scheduler #(
    parameter int            N           = 32,
    parameter int            Q           = 16,
    parameter int            NUM_NEURONS = 4,
    parameter int            IDX_W       = 2,
    parameter logic [N-1:0]  DT          = 32'h0000_8000,
    parameter logic [N-1:0]  V_PEAK      = 32'h001E_0000,
    parameter logic [N-1:0]  C           = 32'h8041_0000,
    parameter logic [N-1:0]  D           = 32'h0008_0000,
    parameter logic [N-1:0]  W_INIT      = 32'h800D_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_NEURONS-1:0] spike_vec,
    input  logic                   cur_we,
    input  logic [IDX_W-1:0]       cur_idx,
    input  logic [N-1:0]           cur_data,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [N-1:0]           rd_v,
    output logic [N-1:0]           rd_w,
    output logic [N-1:0]           dv_v,
    output logic [N-1:0]           dv_w,
    output logic [N-1:0]           dv_i,
    input  logic [N-1:0]           dv_in,
    input  logic [N-1:0]           dw_in
);

    // Handshake: start is a request sampled only while idle (no queueing);
    // done is a one-cycle completion pulse; busy covers the whole sweep.
    typedef enum logic [1:0] {IDLE, ISSUE, UPDATE, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic [N-1:0]     dv_r;
    logic [N-1:0]     dw_r;
    logic [N-1:0]     v_mem [NUM_NEURONS];
    logic [N-1:0]     w_mem [NUM_NEURONS];
    logic [N-1:0]     i_mem [NUM_NEURONS];
    logic [N-1:0]     vn;
    logic [N-1:0]     wn;
    logic [N-1:0]     wn_spk;
    logic             spike;

    // Sign-magnitude multiply; product truncated to Q fraction bits, zero kept positive.
    function automatic logic [N-1:0] sm_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-3:0] p;
        logic [N-2:0]   m;
        p = {{(N-1){1'b0}}, a[N-2:0]} * {{(N-1){1'b0}}, b[N-2:0]};
        m = p[Q+N-2:Q];
        return (m == '0) ? '0 : {a[N-1] ^ b[N-1], m};
    endfunction

    function automatic logic [N-1:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-2:0] m;
        logic         s;
        if (a[N-1] == b[N-1]) begin
            m = a[N-2:0] + b[N-2:0];
            s = a[N-1];
        end else if (a[N-2:0] >= b[N-2:0]) begin
            m = a[N-2:0] - b[N-2:0];
            s = a[N-1];
        end else begin
            m = b[N-2:0] - a[N-2:0];
            s = b[N-1];
        end
        return (m == '0) ? '0 : {s, m};
    endfunction

    assign idx_next = idx + 1'b1;
    assign vn       = sm_add(dv_v, sm_mul(DT, dv_r));
    assign wn       = sm_add(dv_w, sm_mul(DT, dw_r));
    assign wn_spk   = sm_add(wn, D);
    // A negative vn (including a stray -0) never reaches a positive threshold.
    assign spike    = !vn[N-1] && (vn[N-2:0] >= V_PEAK[N-2:0]);

    assign rd_v = v_mem[rd_idx];
    assign rd_w = w_mem[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            spike_vec <= '0;
            dv_v      <= '0;
            dv_w      <= '0;
            dv_i      <= '0;
            dv_r      <= '0;
            dw_r      <= '0;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                v_mem[k] <= C;
                w_mem[k] <= W_INIT;
                i_mem[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (cur_we) begin
                i_mem[cur_idx] <= cur_data;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        dv_v      <= v_mem[0];
                        dv_w      <= w_mem[0];
                        dv_i      <= i_mem[0];
                        spike_vec <= '0;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    dv_r  <= dv_in;
                    dw_r  <= dw_in;
                    state <= UPDATE;
                end
                UPDATE: begin
                    if (spike) begin
                        v_mem[idx]     <= C;
                        w_mem[idx]     <= wn_spk;
                        spike_vec[idx] <= 1'b1;
                    end else begin
                        v_mem[idx] <= vn;
                        w_mem[idx] <= wn;
                    end
                    if (idx == LAST) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        // Next neuron's operands come from the arrays, never from this update.
                        idx   <= idx_next;
                        dv_v  <= v_mem[idx_next];
                        dv_w  <= w_mem[idx_next];
                        dv_i  <= i_mem[idx_next];
                        state <= ISSUE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_izh_update_scheduler.sv
// Self-checking bench for izh_update_scheduler: directed sweeps with a stubbed
// derivative datapath plus randomized sweeps checked against an integer model.
module tb_izh_update_scheduler;

    localparam int          NN     = 4;
    localparam logic [31:0] C_V    = 32'h8041_0000;
    localparam logic [31:0] W_I    = 32'h800D_0000;
    localparam longint      ONE    = 65536;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic [NN-1:0] spike_vec;
    logic          cur_we;
    logic [1:0]    cur_idx;
    logic [31:0]   cur_data;
    logic [1:0]    rd_idx;
    logic [31:0]   rd_v;
    logic [31:0]   rd_w;
    logic [31:0]   dv_v;
    logic [31:0]   dv_w;
    logic [31:0]   dv_i;
    logic [31:0]   dv_in;
    logic [31:0]   dw_in;

    logic          use_model;
    logic [31:0]   stub_dv;
    logic [31:0]   stub_dw;
    logic [31:0]   dw_k;

    int n_vec;
    int n_err;

    // Model state as plain signed fixed-point integers (value * 2^16).
    longint v_m [NN];
    longint w_m [NN];
    longint i_m [NN];

    izh_update_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .spike_vec (spike_vec),
        .cur_we    (cur_we),
        .cur_idx   (cur_idx),
        .cur_data  (cur_data),
        .rd_idx    (rd_idx),
        .rd_v      (rd_v),
        .rd_w      (rd_w),
        .dv_v      (dv_v),
        .dv_w      (dv_w),
        .dv_i      (dv_i),
        .dv_in     (dv_in),
        .dw_in     (dw_in)
    );

    // External derivative stand-in: a constant stub, or dv = i and dw = per-sweep constant.
    assign dv_in = use_model ? dv_i : stub_dv;
    assign dw_in = use_model ? dw_k : stub_dw;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic longint sm2i(input logic [31:0] x);
        return x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
    endfunction

    function automatic logic [31:0] i2sm(input longint x);
        logic [31:0] r;
        if (x < 0) r = {1'b1, 31'(-x)};
        else       r = {1'b0, 31'(x)};
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < NN; n++) begin
            v_m[n] = sm2i(C_V);
            w_m[n] = sm2i(W_I);
            i_m[n] = 0;
        end
    endtask

    task automatic write_cur(input logic [1:0] idx, input logic [31:0] data);
        @(negedge clk);
        cur_we   = 1'b1;
        cur_idx  = idx;
        cur_data = data;
        @(negedge clk);
        cur_we   = 1'b0;
    endtask

    // Pulses (or holds) start; reports when done rose, how often, busy cycles, spike_vec in cycle 1.
    task automatic run_sweep(input bit hold, output int done_at, output int n_done,
                             output int n_busy, output logic [NN-1:0] sv1);
        done_at = -1;
        n_done  = 0;
        n_busy  = 0;
        sv1     = '1;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) sv1 = spike_vec;
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = c;
                start = 1'b0;
            end else if (!hold) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || spike_vec !== '0) begin
            n_err++;
            $display("FAIL reset_flags: busy=%b done=%b spike_vec=%h, want 0/0/0", busy, done, spike_vec);
        end
        n_vec++;
        if (dv_v !== '0 || dv_w !== '0 || dv_i !== '0) begin
            n_err++;
            $display("FAIL reset_operands: dv_v=%h dv_w=%h dv_i=%h, want 0", dv_v, dv_w, dv_i);
        end
        for (int n = 0; n < NN; n++) begin
            rd_idx = 2'(n);
            #1;
            n_vec++;
            if (rd_v !== C_V || rd_w !== W_I) begin
                n_err++;
                $display("FAIL reset_array[%0d]: v=%h w=%h, want %h %h", n, rd_v, rd_w, C_V, W_I);
            end
        end
    endtask

    task automatic test_subthreshold();
        int da, nd, nb;
        logic [NN-1:0] sv1;
        do_reset();
        use_model = 1'b0;
        stub_dv   = 32'h0002_0000;
        stub_dw   = 32'h0;
        run_sweep(1'b0, da, nd, nb, sv1);
        n_vec++;
        if (da !== 9 || nd !== 1) begin
            n_err++;
            $display("FAIL sub_done_timing: done at cycle %0d count %0d, want 9 and 1", da, nd);
        end
        n_vec++;
        if (nb !== 9) begin
            n_err++;
            $display("FAIL sub_busy_cycles: busy for %0d cycles, want 9", nb);
        end
        n_vec++;
        if (spike_vec !== '0) begin
            n_err++;
            $display("FAIL sub_spike_vec: got %h want 0", spike_vec);
        end
        for (int n = 0; n < NN; n++) begin
            rd_idx = 2'(n);
            #1;
            n_vec++;
            if (rd_v !== 32'h8040_0000 || rd_w !== W_I) begin
                n_err++;
                $display("FAIL sub_array[%0d]: v=%h w=%h, want 80400000 %h", n, rd_v, rd_w, W_I);
            end
        end
    endtask

    task automatic test_spike();
        int da, nd, nb;
        logic [NN-1:0] sv1;
        do_reset();
        use_model = 1'b0;
        stub_dv   = 32'h00C8_0000;
        stub_dw   = 32'h0;
        run_sweep(1'b0, da, nd, nb, sv1);
        n_vec++;
        if (spike_vec !== 4'hF || da !== 9) begin
            n_err++;
            $display("FAIL spike_vec: got %h done at %0d, want F at 9", spike_vec, da);
        end
        for (int n = 0; n < NN; n++) begin
            rd_idx = 2'(n);
            #1;
            n_vec++;
            if (rd_v !== C_V || rd_w !== 32'h8005_0000) begin
                n_err++;
                $display("FAIL spike_array[%0d]: v=%h w=%h, want %h 80050000", n, rd_v, rd_w, C_V);
            end
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (spike_vec !== 4'hF) begin
            n_err++;
            $display("FAIL spike_hold: got %h want F", spike_vec);
        end
    endtask

    task automatic test_boundary();
        int da, nd, nb;
        logic [NN-1:0] sv1;
        do_reset();
        use_model = 1'b0;
        stub_dw   = 32'h0;
        stub_dv   = 32'h00BE_0000;
        run_sweep(1'b0, da, nd, nb, sv1);
        rd_idx = 2'd1;
        #1;
        n_vec++;
        if (spike_vec !== 4'hF || rd_v !== C_V || rd_w !== 32'h8005_0000) begin
            n_err++;
            $display("FAIL boundary_at_peak: sv=%h v=%h w=%h, want F %h 80050000", spike_vec, rd_v, rd_w, C_V);
        end
        stub_dv = 32'h00BD_FFFE;
        run_sweep(1'b0, da, nd, nb, sv1);
        n_vec++;
        if (sv1 !== '0) begin
            n_err++;
            $display("FAIL spike_clear_on_start: got %h want 0", sv1);
        end
        n_vec++;
        if (spike_vec !== '0) begin
            n_err++;
            $display("FAIL boundary_below_sv: got %h want 0", spike_vec);
        end
        for (int n = 0; n < NN; n++) begin
            rd_idx = 2'(n);
            #1;
            n_vec++;
            if (rd_v !== 32'h001D_FFFF || rd_w !== 32'h8005_0000) begin
                n_err++;
                $display("FAIL boundary_below[%0d]: v=%h w=%h, want 001dffff 80050000", n, rd_v, rd_w);
            end
        end
    endtask

    task automatic test_back_to_back();
        int da, nd, nb;
        logic [NN-1:0] sv1;
        do_reset();
        use_model = 1'b0;
        stub_dv   = 32'h0002_0000;
        stub_dw   = 32'h0;
        run_sweep(1'b1, da, nd, nb, sv1);
        n_vec++;
        if (nd !== 1 || da !== 9) begin
            n_err++;
            $display("FAIL held_start: %0d dones first at %0d, want 1 at 9", nd, da);
        end
        run_sweep(1'b0, da, nd, nb, sv1);
        n_vec++;
        if (nd !== 1 || da !== 9) begin
            n_err++;
            $display("FAIL second_sweep: %0d dones first at %0d, want 1 at 9", nd, da);
        end
        rd_idx = 2'd3;
        #1;
        n_vec++;
        if (rd_v !== 32'h803F_0000) begin
            n_err++;
            $display("FAIL two_sweeps_v: got %h want 803f0000", rd_v);
        end
    endtask

    task automatic test_midsweep();
        int nd;
        logic [31:0] new2;
        // Current writes racing the operand latch.
        do_reset();
        use_model = 1'b0;
        stub_dv   = 32'h0;
        stub_dw   = 32'h0;
        new2      = {1'b0, 31'($urandom_range(1, 32'h7FFF_FFFF))};
        @(negedge clk);
        start    = 1'b1;
        cur_we   = 1'b1;
        cur_idx  = 2'd0;
        cur_data = 32'h0005_0000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (dv_i !== 32'h0) begin
            n_err++;
            $display("FAIL same_cycle_write: dv_i=%h want 0", dv_i);
        end
        cur_idx  = 2'd2;
        cur_data = new2;
        for (int c = 2; c <= 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            cur_we = 1'b0;
        end
        n_vec++;
        if (dv_i !== new2) begin
            n_err++;
            $display("FAIL early_write_idx2: dv_i=%h want %h", dv_i, new2);
        end
        repeat (8) @(negedge clk);

        // Reset while UPDATE of neuron 1 is in progress.
        do_reset();
        stub_dv = 32'h0002_0000;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        rd_idx = 2'd0;
        #1;
        n_vec++;
        if (rd_v !== 32'h8040_0000 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL partial_readout: v=%h busy=%b, want 80400000 1", rd_v, busy);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_v !== C_V) begin
            n_err++;
            $display("FAIL async_reset: busy=%b done=%b v0=%h, want 0 0 %h", busy, done, rd_v, C_V);
        end
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) nd++;
        end
        n_vec++;
        if (nd !== 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL aborted_sweep: %0d dones busy=%b, want 0 0", nd, busy);
        end
    endtask

    task automatic test_random();
        int da, nd, nb;
        logic [NN-1:0] sv1;
        logic [NN-1:0] exp_sv;
        longint vn, wn;
        logic [31:0] x;
        do_reset();
        use_model = 1'b1;
        for (int s = 0; s < 6; s++) begin
            for (int n = 0; n < NN; n++) begin
                x = {1'b0, 31'($urandom_range(0, 300 * 65536))};
                if (x[30:0] != '0) x[31] = 1'($urandom_range(0, 1));
                write_cur(2'(n), x);
                i_m[n] = sm2i(x);
            end
            dw_k = {1'b0, 31'($urandom_range(0, 20 * 65536))};
            if (dw_k[30:0] != '0) dw_k[31] = 1'($urandom_range(0, 1));
            run_sweep(1'b0, da, nd, nb, sv1);
            exp_sv = '0;
            for (int n = 0; n < NN; n++) begin
                vn = v_m[n] + (32768 * i_m[n]) / ONE;
                wn = w_m[n] + (32768 * sm2i(dw_k)) / ONE;
                if (vn >= 30 * ONE) begin
                    exp_sv[n] = 1'b1;
                    v_m[n]    = sm2i(C_V);
                    w_m[n]    = wn + 8 * ONE;
                end else begin
                    v_m[n] = vn;
                    w_m[n] = wn;
                end
            end
            n_vec++;
            if (spike_vec !== exp_sv || da !== 9) begin
                n_err++;
                $display("FAIL rand_sweep%0d: sv=%h done at %0d, want %h at 9", s, spike_vec, da, exp_sv);
            end
            for (int n = 0; n < NN; n++) begin
                rd_idx = 2'(n);
                #1;
                n_vec++;
                if (rd_v !== i2sm(v_m[n]) || rd_w !== i2sm(w_m[n])) begin
                    n_err++;
                    $display("FAIL rand_state s%0d n%0d: v=%h w=%h, want %h %h",
                             s, n, rd_v, rd_w, i2sm(v_m[n]), i2sm(w_m[n]));
                end
            end
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        cur_we    = 1'b0;
        cur_idx   = '0;
        cur_data  = '0;
        rd_idx    = '0;
        use_model = 1'b0;
        stub_dv   = '0;
        stub_dw   = '0;
        dw_k      = '0;
        test_reset();
        test_subthreshold();
        test_spike();
        test_boundary();
        test_back_to_back();
        test_midsweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
